// File: rtl/bram_arbiter_2m.sv
// Two-master round-robin arbiter for one single-port 32-bit BRAM.
// Ports: clk/resetn; m0_*/m1_* native memory ports (valid, addr, wdata,
//   wstrb in; ready, rdata out); bram_addr/bram_din/bram_we out and
//   bram_dout in (1-cycle registered read); busy, oor_err status;
//   stat_gnt0/stat_gnt1/stat_wait counters.
// Optional: define BRAM_ARBITER_STATS_EN for the saturating counters;
//   otherwise the stat_* outputs are tied to zero.
module bram_arbiter_2m #(
    parameter int          ADDR_WIDTH = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  m0_valid,
    input  logic [31:0]           m0_addr,
    input  logic [31:0]           m0_wdata,
    input  logic [3:0]            m0_wstrb,
    output logic                  m0_ready,
    output logic [31:0]           m0_rdata,
    input  logic                  m1_valid,
    input  logic [31:0]           m1_addr,
    input  logic [31:0]           m1_wdata,
    input  logic [3:0]            m1_wstrb,
    output logic                  m1_ready,
    output logic [31:0]           m1_rdata,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [31:0]           bram_din,
    output logic [3:0]            bram_we,
    input  logic [31:0]           bram_dout,
    output logic                  busy,
    output logic                  oor_err,
    output logic [31:0]           stat_gnt0,
    output logic [31:0]           stat_gnt1,
    output logic [31:0]           stat_wait
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } state_t;

    localparam logic [32:0] WIN_BYTES = 33'd1 << (ADDR_WIDTH + 2);

    state_t      state;
    logic        gnt;
    logic        last_served;
    logic        inwin_q;
    logic        rd_q;

    logic        pick;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_wstrb;
    logic [31:0] off;
    logic        win;
    logic [31:0] rd_word;

    // On a tie the master that was not served last wins.
    always_comb begin
        pick      = (m0_valid && m1_valid) ? ~last_served : m1_valid;
        sel_addr  = pick ? m1_addr  : m0_addr;
        sel_wdata = pick ? m1_wdata : m0_wdata;
        sel_wstrb = pick ? m1_wstrb : m0_wstrb;
        off       = sel_addr - BASE_ADDR;
        win       = ({1'b0, off} < WIN_BYTES);
    end

    // BRAM outputs are loaded on the IDLE->ISSUE edge so they are
    // presented exactly during ISSUE; the read word arrives in DONE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            gnt         <= 1'b0;
            last_served <= 1'b1;
            inwin_q     <= 1'b0;
            rd_q        <= 1'b0;
            bram_addr   <= '0;
            bram_din    <= '0;
            bram_we     <= '0;
            m0_ready    <= 1'b0;
            m1_ready    <= 1'b0;
            oor_err     <= 1'b0;
        end else begin
            bram_we  <= '0;
            m0_ready <= 1'b0;
            m1_ready <= 1'b0;
            oor_err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (m0_valid || m1_valid) begin
                        gnt       <= pick;
                        inwin_q   <= win;
                        rd_q      <= win && (sel_wstrb == 4'h0);
                        bram_addr <= sel_addr[ADDR_WIDTH+1:2];
                        bram_din  <= sel_wdata;
                        bram_we   <= win ? sel_wstrb : 4'h0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    m0_ready <= ~gnt;
                    m1_ready <= gnt;
                    oor_err  <= ~inwin_q;
                    state    <= DONE;
                end
                DONE: begin
                    last_served <= gnt;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        busy     = (state != IDLE);
        rd_word  = (state == DONE && rd_q) ? bram_dout : 32'h0;
        m0_rdata = gnt ? 32'h0 : rd_word;
        m1_rdata = gnt ? rd_word : 32'h0;
    end

`ifdef BRAM_ARBITER_STATS_EN
    logic wait_now;

    // In IDLE only a tie leaves someone waiting; otherwise any valid
    // master that is not the current grant is waiting.
    always_comb begin
        if (state == IDLE)
            wait_now = m0_valid && m1_valid;
        else
            wait_now = (m0_valid && gnt) || (m1_valid && !gnt);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_gnt0 <= '0;
            stat_gnt1 <= '0;
            stat_wait <= '0;
        end else begin
            if (state == DONE && !gnt && stat_gnt0 != 32'hFFFF_FFFF)
                stat_gnt0 <= stat_gnt0 + 32'd1;
            if (state == DONE && gnt && stat_gnt1 != 32'hFFFF_FFFF)
                stat_gnt1 <= stat_gnt1 + 32'd1;
            if (wait_now && stat_wait != 32'hFFFF_FFFF)
                stat_wait <= stat_wait + 32'd1;
        end
    end
`else
    assign stat_gnt0 = 32'h0;
    assign stat_gnt1 = 32'h0;
    assign stat_wait = 32'h0;
`endif

endmodule
